// File: rtl/gb_mem_pkg.sv
// rtl/gb_mem_pkg.sv - shared memory-map constants and DMA state encoding
//
// Purpose : constants shared by the MMU and the OAM DMA engine, plus the
//           DMA engine state type.
// Ports   : none (package).
package gb_mem_pkg;

    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam int          OAM_LEN_C     = 160;
    // The MMU treats this address on the DMA port as "no DMA in progress".
    localparam logic [15:0] BUS_IDLE_ADDR = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        RD,
        LATCH,
        WR
    } dma_state_t;

endpackage

// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - OAM DMA controller owning the 0xFF46 register
//
// Purpose : on each CPU write to 0xFF46 copies OAM_LEN bytes from
//           {src_hi, 8'h00} onward into OAM at 0xFE00, three bus cycles
//           per byte (read address, latch data, write OAM).
// Ports   : clk, rst (async, active-high)
//           mmio_addr/mmio_wdata/mmio_we/mmio_rdata : CPU register slave
//           dma_addr/dma_wdata/dma_we/dma_rdata     : bus master to the MMU
//           active : high from the start delay through the final OAM write
module oam_dma_engine
    import gb_mem_pkg::*;
#(
    parameter int START_DELAY = 1,
    parameter int OAM_LEN     = OAM_LEN_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mmio_addr,
    input  logic [7:0]  mmio_wdata,
    input  logic        mmio_we,
    output logic [7:0]  mmio_rdata,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_we,
    input  logic [7:0]  dma_rdata,
    output logic        active
);

    localparam logic [7:0] LAST_IDX   = 8'(OAM_LEN - 1);
    // Only meaningful when START_DELAY > 0; DELAY is never entered otherwise.
    localparam logic [7:0] DELAY_LAST = 8'((START_DELAY > 0) ? (START_DELAY - 1) : 0);

    dma_state_t state_q, state_d;
    logic [7:0] dma_reg_q, dma_reg_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] byte_idx_q, byte_idx_d;
    logic [7:0] data_latch_q, data_latch_d;
    logic [7:0] delay_cnt_q, delay_cnt_d;

    logic       reg_wr;
    logic [7:0] eff_src;

    assign reg_wr = mmio_we && (mmio_addr == DMA_REG_ADDR);

    // Sources at 0xE0 and above fall in echo RAM; fold them back onto WRAM.
    assign eff_src = (mmio_wdata >= 8'hE0) ? (mmio_wdata - 8'h20) : mmio_wdata;

    assign mmio_rdata = (mmio_addr == DMA_REG_ADDR) ? dma_reg_q : 8'hFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dma_reg_q    <= 8'hFF;
            src_hi_q     <= 8'h00;
            byte_idx_q   <= 8'h00;
            data_latch_q <= 8'h00;
            delay_cnt_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            dma_reg_q    <= dma_reg_d;
            src_hi_q     <= src_hi_d;
            byte_idx_q   <= byte_idx_d;
            data_latch_q <= data_latch_d;
            delay_cnt_q  <= delay_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dma_reg_d    = dma_reg_q;
        src_hi_d     = src_hi_q;
        byte_idx_d   = byte_idx_q;
        data_latch_d = data_latch_q;
        delay_cnt_d  = delay_cnt_q;

        case (state_q)
            IDLE: ;
            DELAY: begin
                if (delay_cnt_q == DELAY_LAST) begin
                    state_d = RD;
                end else begin
                    delay_cnt_d = delay_cnt_q + 8'd1;
                end
            end
            RD:    state_d = LATCH;
            LATCH: begin
                // Synchronous RAM: data for the address presented in RD is
                // on dma_rdata during this cycle.
                data_latch_d = dma_rdata;
                state_d      = WR;
            end
            WR: begin
                if (byte_idx_q == LAST_IDX) begin
                    byte_idx_d = 8'h00;
                    state_d    = IDLE;
                end else begin
                    byte_idx_d = byte_idx_q + 8'd1;
                    state_d    = RD;
                end
            end
            default: state_d = IDLE;
        endcase

        // A register write restarts from byte 0 in any state. The bus outputs
        // of the current cycle are unaffected, so a final WR still lands.
        if (reg_wr) begin
            dma_reg_d   = mmio_wdata;
            src_hi_d    = eff_src;
            byte_idx_d  = 8'h00;
            delay_cnt_d = 8'h00;
            state_d     = (START_DELAY == 0) ? RD : DELAY;
        end
    end

    // Bus outputs decode straight from the state so an asynchronous reset
    // releases the bus immediately.
    always_comb begin
        dma_addr  = BUS_IDLE_ADDR;
        dma_wdata = 8'h00;
        dma_we    = 1'b0;
        case (state_q)
            RD, LATCH: dma_addr = {src_hi_q, byte_idx_q};
            WR: begin
                dma_addr  = OAM_BASE + {8'h00, byte_idx_q};
                dma_wdata = data_latch_q;
                dma_we    = 1'b1;
            end
            default: ;
        endcase
    end

    assign active = (state_q != IDLE);

endmodule

// File: tb/tb_oam_dma_engine.sv
// tb/tb_oam_dma_engine.sv - self-checking bench for oam_dma_engine
module tb_oam_dma_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mmio_addr;
    logic [7:0]  mmio_wdata;
    logic        mmio_we;
    logic [7:0]  mmio_rdata;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_we;
    logic [7:0]  dma_rdata;
    logic        active;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;

    oam_dma_engine dut (
        .clk        (clk),
        .rst        (rst),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_we    (mmio_we),
        .mmio_rdata (mmio_rdata),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_we     (dma_we),
        .dma_rdata  (dma_rdata),
        .active     (active)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model of the whole address space behind the MMU.
    always @(posedge clk) begin
        dma_rdata <= mem[dma_addr];
        if (dma_we) mem[dma_addr] = dma_wdata;
    end

    typedef struct {
        logic        wr_en;
        logic [15:0] wr_addr;
        logic [7:0]  wr_data;
        logic [15:0] rd_addr;
        logic [7:0]  exp_rdata;
        logic        exp_active;
    } reg_vec_t;

    typedef struct {
        logic [7:0]  wdata;
        logic [15:0] exp_addr;
    } src_vec_t;

    reg_vec_t rv [6];
    src_vec_t sv [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [15:0] addr, input logic [7:0] data);
        mmio_addr  = addr;
        mmio_wdata = data;
        mmio_we    = 1'b1;
        tick();
        mmio_we    = 1'b0;
        mmio_addr  = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_oam(input logic [7:0] v);
        for (int i = 0; i < 160; i++) mem[16'hFE00 + i] = v;
    endtask

    // Counts active cycles from the current one and checks the bus pattern.
    task automatic run_transfer(input logic [7:0] src, output int cycles, output int bus_bad);
        int          run;
        logic [15:0] last;
        cycles  = 0;
        bus_bad = 0;
        run     = 0;
        last    = 16'hFFFF;
        while (active && cycles < 1000) begin
            cycles++;
            if (dma_we) begin
                if (dma_addr < 16'hFE00 || dma_addr > 16'hFE9F) bus_bad++;
                if (run != 2) bus_bad++;
                if (last[15:8] != src || last[7:0] != dma_addr[7:0]) bus_bad++;
                run = 0;
            end else if (dma_addr != 16'hFFFF) begin
                if (dma_addr[15:8] != src || dma_addr[7:0] > 8'h9F) bus_bad++;
                if (dma_addr == last) run++;
                else run = 1;
            end
            last = dma_addr;
            tick();
        end
    endtask

    function automatic int oam_mismatch(input logic [15:0] src_base, input logic [7:0] key);
        int bad = 0;
        for (int i = 0; i < 160; i++) begin
            if (mem[16'hFE00 + i] !== (8'(i) ^ key)) bad++;
            if (mem[src_base + 16'(i)] !== (8'(i) ^ key)) bad++;
        end
        return bad;
    endfunction

    initial begin
        int cyc;
        int bad;
        int pre;

        rv[0] = '{1'b0, 16'h0000, 8'h00, 16'hFF46, 8'hC0, 1'b0};
        rv[1] = '{1'b0, 16'h0000, 8'h00, 16'hFF47, 8'hFF, 1'b0};
        rv[2] = '{1'b1, 16'hFF47, 8'h12, 16'hFF46, 8'hC0, 1'b0};
        rv[3] = '{1'b1, 16'hFF46, 8'h80, 16'hFF46, 8'h80, 1'b1};
        rv[4] = '{1'b0, 16'h0000, 8'h00, 16'hFF45, 8'hFF, 1'b1};
        rv[5] = '{1'b0, 16'h0000, 8'h00, 16'hFF46, 8'h80, 1'b1};

        sv[0] = '{8'hFE, 16'hDE00};
        sv[1] = '{8'hE0, 16'hC000};
        sv[2] = '{8'hDF, 16'hDF00};
        sv[3] = '{8'hFF, 16'hDF00};
        sv[4] = '{8'h00, 16'h0000};
        sv[5] = '{8'hC1, 16'hC100};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
            mem[16'hC100 + i] = 8'(i) ^ 8'h33;
            mem[16'hDE00 + i] = 8'(i) ^ 8'hA5;
        end

        rst        = 1'b1;
        mmio_addr  = 16'hFF46;
        mmio_wdata = 8'h00;
        mmio_we    = 1'b0;
        #2;
        check("reset_dma_addr", 32'(dma_addr), 32'hFFFF);
        check("reset_dma_we", 32'(dma_we), 32'h0);
        check("reset_dma_wdata", 32'(dma_wdata), 32'h0);
        check("reset_active", 32'(active), 32'h0);
        check("reset_reg_read", 32'(mmio_rdata), 32'hFF);
        tick();
        tick();
        rst = 1'b0;

        // Basic transfer from 0xC0.
        write_reg(16'hFF46, 8'hC0);
        run_transfer(8'hC0, cyc, bad);
        check("basic_active_cycles", 32'(cyc), 32'd481);
        check("basic_bus_pattern", 32'(bad), 32'd0);
        check("basic_oam_data", 32'(oam_mismatch(16'hC000, 8'h5A)), 32'd0);
        check("basic_idle_addr", 32'(dma_addr), 32'hFFFF);

        // Register access table.
        for (int i = 0; i < 6; i++) begin
            if (rv[i].wr_en) begin
                mmio_addr  = rv[i].wr_addr;
                mmio_wdata = rv[i].wr_data;
                mmio_we    = 1'b1;
            end
            tick();
            mmio_we   = 1'b0;
            mmio_addr = rv[i].rd_addr;
            #1;
            check($sformatf("reg_vec%0d_rdata", i), 32'(mmio_rdata), 32'(rv[i].exp_rdata));
            check($sformatf("reg_vec%0d_active", i), 32'(active), 32'(rv[i].exp_active));
        end
        do_reset();
        mmio_addr = 16'hFF46;
        #1;
        check("reg_after_reset", 32'(mmio_rdata), 32'hFF);

        // Effective source table: first RD address after the delay cycle.
        for (int i = 0; i < 6; i++) begin
            write_reg(16'hFF46, sv[i].wdata);
            check($sformatf("src_vec%0d_delay_addr", i), 32'(dma_addr), 32'hFFFF);
            tick();
            check($sformatf("src_vec%0d_rd_addr", i), 32'(dma_addr), 32'(sv[i].exp_addr));
            check($sformatf("src_vec%0d_rd_we", i), 32'(dma_we), 32'h0);
        end
        do_reset();

        // Full echo transfer from 0xFE.
        fill_oam(8'h00);
        write_reg(16'hFF46, 8'hFE);
        run_transfer(8'hDE, cyc, bad);
        check("echo_active_cycles", 32'(cyc), 32'd481);
        check("echo_bus_pattern", 32'(bad), 32'd0);
        check("echo_oam_data", 32'(oam_mismatch(16'hDE00, 8'hA5)), 32'd0);

        // Restart during the WR of byte 49.
        fill_oam(8'h00);
        write_reg(16'hFF46, 8'hC0);
        repeat (150) tick();
        check("restart_wr49_we", 32'(dma_we), 32'h1);
        check("restart_wr49_addr", 32'(dma_addr), 32'hFE31);
        write_reg(16'hFF46, 8'hC1);
        check("restart_wr49_landed", 32'(mem[16'hFE31]), 32'(8'h31 ^ 8'h5A));
        check("restart_delay_addr", 32'(dma_addr), 32'hFFFF);
        pre = 152;
        tick();
        check("restart_first_rd", 32'(dma_addr), 32'hC100);
        run_transfer(8'hC1, cyc, bad);
        check("restart_total_cycles", 32'(pre + cyc), 32'd632);
        check("restart_bus_pattern", 32'(bad), 32'd0);
        check("restart_oam_data", 32'(oam_mismatch(16'hC100, 8'h33)), 32'd0);

        // Asynchronous reset during the WR of byte 10.
        fill_oam(8'hEE);
        write_reg(16'hFF46, 8'hC0);
        repeat (33) tick();
        check("rstmid_wr10_we", 32'(dma_we), 32'h1);
        check("rstmid_wr10_addr", 32'(dma_addr), 32'hFE0A);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_we", 32'(dma_we), 32'h0);
        check("rstmid_addr", 32'(dma_addr), 32'hFFFF);
        check("rstmid_active", 32'(active), 32'h0);
        repeat (3) tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 11; i < 160; i++) if (mem[16'hFE00 + i] !== 8'hEE) bad++;
        check("rstmid_oam_untouched", 32'(bad), 32'd0);
        check("rstmid_byte9_written", 32'(mem[16'hFE09]), 32'(8'h09 ^ 8'h5A));
        mmio_addr = 16'hFF46;
        #1;
        check("rstmid_reg_read", 32'(mmio_rdata), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma_engine.md
Name: oam_dma_engine

Overview:
- OAM DMA controller. Owns the 0xFF46 DMA register, which is written by the CPU through the MMU's mmio_dma_if.
- On each write to that register it copies 160 bytes from {src_hi, 8'h00}..{src_hi, 8'h9F} to OAM 0xFE00..0xFE9F.
- It is the master that drives the MMU's dma_req port, which the MMU arbitrates against the CPU and PPU.
- While a copy is running, the MMU blocks CPU access to OAM.

Parameters:
- START_DELAY, 1: cycles between the register write and the first source read. dma_addr stays at the idle value during this time.
- OAM_LEN, 160: number of bytes per transfer.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mmio_addr  in  16  CPU address routed by the MMU (mmio_dma_if.addr_select)
- mmio_wdata  in  8  CPU write data (mmio_dma_if.write_value)
- mmio_we  in  1  CPU write enable (mmio_dma_if.write_enable)
- mmio_rdata  out  8  register read data (mmio_dma_if.read_out), combinational
- dma_addr  out  16  bus address to the MMU (dma_req.addr_select)
- dma_wdata  out  8  bus write data (dma_req.write_value)
- dma_we  out  1  bus write enable (dma_req.write_enable)
- dma_rdata  in  8  bus read data (dma_req.read_out). Valid 1 cycle after dma_addr is presented (synchronous RAM).
- active  out  1  high while a transfer is in progress (DELAY through the final WR)

Behaviour:
- Reset (async): state=IDLE, dma_reg=8'hFF, byte_idx=0, data_latch=0, dma_addr=16'hFFFF, dma_we=0, dma_wdata=0, active=0.
- Idle bus: in IDLE and DELAY the block drives dma_addr=16'hFFFF, dma_we=0. The MMU reads 0xFFFF as "no DMA in progress".
- Register read: mmio_rdata = dma_reg when mmio_addr==16'hFF46, otherwise 8'hFF.
- Register write: on a clk edge with mmio_we && mmio_addr==16'hFF46:
  - dma_reg <= mmio_wdata, src_hi <= the effective source, byte_idx <= 0.
  - The state goes to DELAY, or directly to RD if START_DELAY==0.
  - This applies in any state. A write mid-transfer aborts the current copy and restarts from byte 0. Bytes already written stay in OAM.
- Effective source: src_hi = (mmio_wdata >= 8'hE0) ? mmio_wdata - 8'h20 : mmio_wdata. Example: 0xFE maps to 0xDE.
- States:
  - IDLE: wait for a register write.
  - DELAY: count START_DELAY cycles, then go to RD.
  - RD: dma_addr={src_hi, byte_idx}, dma_we=0. Next state LATCH.
  - LATCH: dma_addr held at the source address. data_latch <= dma_rdata at the end of the cycle. Next state WR.
  - WR: dma_addr=16'hFE00+byte_idx, dma_wdata=data_latch, dma_we=1.
    - If byte_idx==OAM_LEN-1: go to IDLE, byte_idx<=0.
    - Otherwise: byte_idx++, go to RD.
- Timing: 3 cycles per byte. With the default START_DELAY=1, a full transfer takes 1+480=481 cycles from the register write to the return to IDLE.
- Widths: byte_idx is 8 bits. Address arithmetic is 16 bits. byte_idx never exceeds 159, so the source low byte never wraps past 0x9F.
- Simultaneous events: a register write in the same cycle as the final WR still performs that write to OAM, then restarts (restart takes priority for the next state).
- The engine never writes outside 0xFE00..0xFE9F.
- No CPU stalling: the CPU continues, and the MMU handles the bus conflict (DMA wins).

Decomposition:
- Shared package gb_mem_pkg holds:
  - DMA_REG_ADDR=16'hFF46
  - OAM_BASE=16'hFE00
  - OAM_LEN_C=160
  - BUS_IDLE_ADDR=16'hFFFF
  - typedef enum dma_state_t {IDLE, DELAY, RD, LATCH, WR}
- The MMU imports the same BUS_IDLE_ADDR.
- Single module; no sub-module is warranted.
- A top-level wrapper connects the flat ports to the mem_if slave/master modports.

Test Plan:
- Basic transfer:
  - Stimulus: preload WRAM 0xC000..0xC09F with i^8'h5A; write 0xC0 to 0xFF46.
  - Required: active=1 for exactly 481 cycles; OAM[i]==i^8'h5A for all 160 bytes; dma_addr==16'hFFFF afterwards.
- Register readback:
  - Stimulus: write 0x80, then read 0xFF46; also read 0xFF47.
  - Required: 0x80 from 0xFF46; 0xFF from 0xFF47. After reset, 0xFF46 reads 0xFF.
- Echo source:
  - Stimulus: write 0xFE.
  - Required: source reads hit 0xDE00..0xDE9F; first RD presents 16'hDE00.
- Restart mid-transfer:
  - Stimulus: write 0xC0; at byte 50 write 0xC1.
  - Required: the next RD address is 16'hC100; OAM ends holding C1xx data for all 160 bytes; total active time is 50*3+1+1+480 cycles.
- Reset mid-transfer:
  - Stimulus: assert rst asynchronously (off-edge) during WR of byte 10.
  - Required: dma_we=0, dma_addr=16'hFFFF, active=0 immediately (before the next clk edge); OAM bytes 11..159 unchanged.
- Bus pattern check:
  - Stimulus: any transfer, monitor the bus.
  - Required: dma_we is high only when dma_addr is in 0xFE00..0xFE9F; every write is preceded by exactly 2 cycles on the source address.
